// File: rtl/exec_trace_pkg.sv
// Shared types and constants for the execution trace capture block.
// Holds the FSM state encoding, default widths and the address-width helper.
package exec_trace_pkg;

  localparam int TRACE_PC_W   = 16;
  localparam int TRACE_DATA_W = 16;
  localparam int ENTRY_W      = TRACE_PC_W + TRACE_DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_READOUT = 3'd4
  } trace_state_e;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int log2_ceil(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/exec_trace_capture_if.sv
// Readout stream of the trace buffer: valid/ready with {pc, alu} payload and a last marker.
// The capture block is the master (it drives valid/data/last); the host is the slave.
interface exec_trace_capture_if
  import exec_trace_pkg::*;
#(
  parameter int PC_W   = TRACE_PC_W,
  parameter int DATA_W = TRACE_DATA_W
) ();

  logic                     rd_valid;
  logic                     rd_ready;
  logic [PC_W+DATA_W-1:0]   rd_data;
  logic                     rd_last;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_last,
    output rd_ready
  );

endinterface

// File: rtl/trace_buf_ram.sv
// Simple dual-port trace storage: synchronous write, asynchronous (combinational) read.
module trace_buf_ram
  import exec_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = ENTRY_W,
  localparam int AW   = log2_ceil(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch on purpose; a reset would turn it into
  // DEPTH*WIDTH flops with reset muxes instead of a RAM, and stale entries are
  // never read because readout is bounded by the captured count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/exec_trace_capture.sv
// Captures retired {pc, alu_result} pairs into a trace buffer, optionally from a trigger PC,
// then streams the captured entries out over a valid/ready port.
module exec_trace_capture
  import exec_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PC_W   = TRACE_PC_W,
  parameter int DATA_W = TRACE_DATA_W,
  localparam int AW    = log2_ceil(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 stop,
  input  logic                 trig_en,
  input  logic [PC_W-1:0]      trig_pc,
  input  logic [PC_W-1:0]      pc_in,
  input  logic [DATA_W-1:0]    alu_in,
  exec_trace_capture_if.master rd_if,
  output logic [AW:0]          count,
  output logic [2:0]           state_o
);

  localparam int EW = PC_W + DATA_W;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_FILL = CW'(DEPTH - 1);

  trace_state_e      state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
  logic              prev_valid_q, prev_valid_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [EW-1:0]     rd_data_q, rd_data_d;

  logic              retire;
  logic              trig_hit;
  logic              wr_en;
  logic [AW-1:0]     rd_ptr_nxt;
  logic [AW-1:0]     rd_addr;
  logic [CW-1:0]     last_idx;
  logic [EW-1:0]     ram_rdata;

  // A new instruction retires whenever the observed PC moves.
  assign retire     = !prev_valid_q || (pc_in != prev_pc_q);
  assign trig_hit   = !trig_en || (pc_in == trig_pc);
  assign rd_ptr_nxt = rd_ptr_q + AW'(1);
  assign last_idx   = count_q - CW'(1);

  // DONE fetches entry 0; during READOUT the next entry is prefetched so a
  // handshake can present it on the following cycle without a bubble.
  assign rd_addr = (state_q == ST_DONE) ? '0 : rd_ptr_nxt;

  trace_buf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en && reset),
    .waddr (wr_ptr_q),
    .wdata ({pc_in, alu_in}),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  always_comb begin
    // NOTE: every _d starts from its _q (or a fixed value) so that no path
    // through the case leaves a signal unassigned and infers a latch.
    state_d      = state_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    rd_data_d    = rd_data_q;
    prev_pc_d    = pc_in;
    prev_valid_d = 1'b1;
    wr_en        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d  = ST_ARMED;
          count_d  = '0;
          wr_ptr_d = '0;
        end
      end

      ST_ARMED, ST_CAPTURE: begin
        // count_q[AW] set means the buffer already holds DEPTH entries.
        wr_en = retire && !count_q[AW] && ((state_q == ST_CAPTURE) || trig_hit);
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CW'(1);
        end
        if ((state_q == ST_ARMED) && (!trig_en || wr_en)) begin
          state_d = ST_CAPTURE;
        end
        if (stop || (wr_en && (count_q == LAST_FILL))) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        rd_ptr_d = '0;
        if (count_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_READOUT;
          rd_valid_d = 1'b1;
          rd_data_d  = ram_rdata;
          rd_last_d  = (count_q == CW'(1));
        end
      end

      ST_READOUT: begin
        if (rd_valid_q && rd_if.rd_ready) begin
          if (rd_last_q) begin
            state_d    = ST_IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
          end else begin
            rd_ptr_d  = rd_ptr_nxt;
            rd_data_d = ram_rdata;
            rd_last_d = ({1'b0, rd_ptr_nxt} == last_idx);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_if.rd_valid = rd_valid_q;
  assign rd_if.rd_data  = rd_data_q;
  assign rd_if.rd_last  = rd_last_q;
  assign count          = count_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_exec_trace_capture.sv
// Directed bench for exec_trace_capture: free-running capture, trigger, PC hold,
// early stop, empty stop, readout back-pressure and reset during readout.
module tb_exec_trace_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        stop;
  logic        trig_en;
  logic [15:0] trig_pc;
  logic [15:0] pc_in;
  logic [15:0] alu_in;
  logic [4:0]  count;
  logic [2:0]  state_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] beat_data [32];
  logic        beat_last [32];

  exec_trace_capture_if #(.PC_W(16), .DATA_W(16)) rd_if ();

  exec_trace_capture #(.DEPTH(16), .PC_W(16), .DATA_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .arm     (arm),
    .stop    (stop),
    .trig_en (trig_en),
    .trig_pc (trig_pc),
    .pc_in   (pc_in),
    .alu_in  (alu_in),
    .rd_if   (rd_if),
    .count   (count),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drain the readout port; stall_mode applies the ready pattern 1,0,0,1.
  task automatic collect(input bit stall_mode, output int n, output bit timed_out,
                         output int unstable);
    logic [31:0] held_data;
    logic        held_last;
    bit          have_hold;
    bit          rdy;
    bit          finished;
    logic [3:0]  pattern;
    pattern   = 4'b1001;
    n         = 0;
    unstable  = 0;
    have_hold = 1'b0;
    finished  = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      if (have_hold && rd_if.rd_valid &&
          (rd_if.rd_data !== held_data || rd_if.rd_last !== held_last)) begin
        unstable++;
      end
      rdy = stall_mode ? pattern[3 - (cyc % 4)] : 1'b1;
      rd_if.rd_ready = rdy;
      if (rd_if.rd_valid && rdy) begin
        if (n < 32) begin
          beat_data[n] = rd_if.rd_data;
          beat_last[n] = rd_if.rd_last;
        end
        n++;
        have_hold = 1'b0;
        if (rd_if.rd_last) finished = 1'b1;
      end else begin
        have_hold = rd_if.rd_valid;
        held_data = rd_if.rd_data;
        held_last = rd_if.rd_last;
      end
      step();
    end
    rd_if.rd_ready = 1'b0;
    timed_out = !finished;
  endtask

  task automatic start_session(input bit use_trig, input logic [15:0] tpc);
    pc_in   = 16'hFFFF;
    alu_in  = 16'h0000;
    trig_en = use_trig;
    trig_pc = tpc;
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; arm = 1'b0; stop = 1'b0; trig_en = 1'b0; trig_pc = '0;
    pc_in = '0; alu_in = '0; rd_if.rd_ready = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (rd_if.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_if.rd_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (rd_if.rd_data !== 32'h0 || rd_if.rd_last !== 1'b0) begin
      bad++; $display("FAIL reset_rd_data got=%h/%b exp=0/0", rd_if.rd_data, rd_if.rd_last);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (3) step();
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL idle_hold got=%0d exp=0", state_o); end
  endtask

  task automatic test_capture_free();
    int n; bit to; int unst;
    start_session(1'b0, 16'h0);
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL free_armed got=%0d exp=1", state_o); end
    for (int i = 0; i < 16; i++) begin
      pc_in  = 16'(i);
      alu_in = 16'(i * 3);
      step();
      if (i == 0) begin
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL free_capture got=%0d exp=2", state_o); end
      end
    end
    total++; if (state_o !== 3'd3) begin bad++; $display("FAIL free_done got=%0d exp=3", state_o); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL free_count got=%0d exp=16", count); end
    total++; if (rd_if.rd_valid !== 1'b0) begin bad++; $display("FAIL free_done_valid got=%b exp=0", rd_if.rd_valid); end
    step();
    total++; if (rd_if.rd_valid !== 1'b1 || state_o !== 3'd4) begin
      bad++; $display("FAIL free_first_valid got=%b/%0d exp=1/4", rd_if.rd_valid, state_o);
    end
    collect(1'b0, n, to, unst);
    total++; if (to || n !== 16) begin bad++; $display("FAIL free_beats got=%0d timeout=%b exp=16", n, to); end
    for (int i = 0; i < 16; i++) begin
      total++; if (beat_data[i] !== {16'(i), 16'(i * 3)} || beat_last[i] !== (i == 15)) begin
        bad++; $display("FAIL free_beat%0d got=%h/%b exp=%h/%b", i, beat_data[i], beat_last[i],
                        {16'(i), 16'(i * 3)}, (i == 15));
      end
    end
    total++; if (state_o !== 3'd0 || rd_if.rd_valid !== 1'b0 || count !== 5'd16) begin
      bad++; $display("FAIL free_exit got=%0d/%b/%0d exp=0/0/16", state_o, rd_if.rd_valid, count);
    end
  endtask

  task automatic test_trigger();
    int n; bit to; int unst;
    logic [15:0] pc;
    start_session(1'b1, 16'h0040);
    for (int p = 16'h38; p <= 16'h50; p++) begin
      pc_in  = 16'(p);
      alu_in = 16'(p * 3);
      step();
      if (p == 16'h3F) begin
        total++; if (state_o !== 3'd1 || count !== 5'd0) begin
          bad++; $display("FAIL trig_wait got=%0d/%0d exp=1/0", state_o, count);
        end
      end
    end
    total++; if (count !== 5'd16 || rd_if.rd_valid !== 1'b1) begin
      bad++; $display("FAIL trig_count got=%0d/%b exp=16/1", count, rd_if.rd_valid);
    end
    collect(1'b0, n, to, unst);
    total++; if (to || n !== 16) begin bad++; $display("FAIL trig_beats got=%0d timeout=%b exp=16", n, to); end
    total++; if (beat_data[0] !== 32'h0040_00C0) begin
      bad++; $display("FAIL trig_first got=%h exp=004000c0", beat_data[0]);
    end
    pc = 16'h004F;
    total++; if (beat_data[15] !== {pc, 16'(pc * 3)} || beat_last[15] !== 1'b1) begin
      bad++; $display("FAIL trig_last got=%h/%b exp=%h/1", beat_data[15], beat_last[15], {pc, 16'(pc * 3)});
    end
  endtask

  task automatic test_pc_hold();
    int n; bit to; int unst;
    start_session(1'b0, 16'h0);
    pc_in = 16'h0010; alu_in = 16'h0030;
    step();
    alu_in = 16'h0099;
    repeat (3) step();
    pc_in = 16'h0011; alu_in = 16'h0033;
    step();
    alu_in = 16'h0055;
    step();
    total++; if (count !== 5'd2) begin bad++; $display("FAIL hold_count got=%0d exp=2", count); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++; if (state_o !== 3'd3 || count !== 5'd2) begin
      bad++; $display("FAIL hold_done got=%0d/%0d exp=3/2", state_o, count);
    end
    collect(1'b0, n, to, unst);
    total++; if (to || n !== 2) begin bad++; $display("FAIL hold_beats got=%0d timeout=%b exp=2", n, to); end
    total++; if (beat_data[0] !== 32'h0010_0030 || beat_data[1] !== 32'h0011_0033) begin
      bad++; $display("FAIL hold_data got=%h,%h exp=00100030,00110033", beat_data[0], beat_data[1]);
    end
  endtask

  task automatic test_stop_early();
    int n; bit to; int unst;
    start_session(1'b0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      pc_in  = 16'(16'h20 + i);
      alu_in = 16'((16'h20 + i) * 3);
      arm    = (i == 2);
      stop   = (i == 4);
      step();
    end
    arm = 1'b0; stop = 1'b0;
    total++; if (state_o !== 3'd3 || count !== 5'd5) begin
      bad++; $display("FAIL stop5_done got=%0d/%0d exp=3/5", state_o, count);
    end
    collect(1'b0, n, to, unst);
    total++; if (to || n !== 5) begin bad++; $display("FAIL stop5_beats got=%0d timeout=%b exp=5", n, to); end
    for (int i = 0; i < 5; i++) begin
      total++; if (beat_data[i] !== {16'(16'h20 + i), 16'((16'h20 + i) * 3)} || beat_last[i] !== (i == 4)) begin
        bad++; $display("FAIL stop5_beat%0d got=%h/%b exp=%h/%b", i, beat_data[i], beat_last[i],
                        {16'(16'h20 + i), 16'((16'h20 + i) * 3)}, (i == 4));
      end
    end
  endtask

  task automatic test_stop_empty();
    start_session(1'b1, 16'h7777);
    pc_in = 16'h0001;
    step();
    pc_in = 16'h0002; stop = 1'b1;
    step();
    stop = 1'b0;
    total++; if (state_o !== 3'd3 || count !== 5'd0 || rd_if.rd_valid !== 1'b0) begin
      bad++; $display("FAIL empty_done got=%0d/%0d/%b exp=3/0/0", state_o, count, rd_if.rd_valid);
    end
    step();
    total++; if (state_o !== 3'd0 || rd_if.rd_valid !== 1'b0) begin
      bad++; $display("FAIL empty_idle got=%0d/%b exp=0/0", state_o, rd_if.rd_valid);
    end
    step();
    total++; if (rd_if.rd_valid !== 1'b0) begin bad++; $display("FAIL empty_novalid got=%b exp=0", rd_if.rd_valid); end
  endtask

  task automatic test_back_to_back_stall();
    int n; bit to; int unst;
    start_session(1'b0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      pc_in  = 16'(16'h30 + i);
      alu_in = 16'(16'h100 + i);
      stop   = (i == 5);
      step();
    end
    stop = 1'b0;
    collect(1'b1, n, to, unst);
    total++; if (to || n !== 6) begin bad++; $display("FAIL stall_beats got=%0d timeout=%b exp=6", n, to); end
    total++; if (unst !== 0) begin bad++; $display("FAIL stall_stable got=%0d changes exp=0", unst); end
    for (int i = 0; i < 6; i++) begin
      total++; if (beat_data[i] !== {16'(16'h30 + i), 16'(16'h100 + i)} || beat_last[i] !== (i == 5)) begin
        bad++; $display("FAIL stall_beat%0d got=%h/%b exp=%h/%b", i, beat_data[i], beat_last[i],
                        {16'(16'h30 + i), 16'(16'h100 + i)}, (i == 5));
      end
    end
  endtask

  task automatic test_reset_readout();
    start_session(1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      pc_in  = 16'(16'h60 + i);
      alu_in = 16'(i);
      stop   = (i == 3);
      step();
    end
    stop = 1'b0;
    step();
    total++; if (rd_if.rd_valid !== 1'b1 || state_o !== 3'd4) begin
      bad++; $display("FAIL rstro_pre got=%b/%0d exp=1/4", rd_if.rd_valid, state_o);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++; if (rd_if.rd_valid !== 1'b0 || state_o !== 3'd0 || count !== 5'd0) begin
      bad++; $display("FAIL rstro_post got=%b/%0d/%0d exp=0/0/0", rd_if.rd_valid, state_o, count);
    end
    total++; if (rd_if.rd_data !== 32'h0 || rd_if.rd_last !== 1'b0) begin
      bad++; $display("FAIL rstro_data got=%h/%b exp=0/0", rd_if.rd_data, rd_if.rd_last);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_capture_free();
    test_trigger();
    test_pc_hold();
    test_stop_early();
    test_stop_empty();
    test_back_to_back_stall();
    test_reset_readout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
